// File: rtl/schedule_request_arbiter_pkg.sv
// Shared definitions for the schedule request arbiter: context class codes,
// FSM state encoding and the class validity check.
// Pure declarations, no logic of its own.
package schedule_request_arbiter_pkg;

    // Context classes accepted by the schedule engine (one-hot class field)
    localparam logic [2:0] CLS_A = 3'b001;
    localparam logic [2:0] CLS_B = 3'b010;
    localparam logic [2:0] CLS_C = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // A context may only reach the engine when its class is one of the known codes
    function automatic logic class_valid(input logic [2:0] cls);
        return (cls == CLS_A) || (cls == CLS_B) || (cls == CLS_C);
    endfunction

endpackage

// File: rtl/schedule_request_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
module schedule_request_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDW-1:0]     idx_o,
    output logic               any_o
);

    int j;

    // Scan from the farthest offset down to ptr so the closest set bit is written last and wins
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = |req_i;
        j        = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (req_i[j]) begin
                onehot_o    = '0;
                onehot_o[j] = 1'b1;
                idx_o       = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/schedule_request_arbiter.sv
// Shares one schedule engine between NUM_REQ requesters with round-robin grant and class check.
// Latency: bad class responds 1 cycle after req; valid class responds 1 cycle after first tx_in.
// Backpressure: one transaction in flight; other requests wait (level req) until the FSM is IDLE.
module schedule_request_arbiter
    import schedule_request_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CTX_W   = 32,
    parameter int SCHED_W = 32,
    parameter int TIMEOUT = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*CTX_W-1:0]    req_context,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        ev_out,
    output logic [CTX_W-1:0]            context_out,
    input  logic                        tx_in,
    input  logic [SCHED_W-1:0]          schedule_in,
    output logic                        rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [SCHED_W-1:0]          rsp_schedule,
    output logic                        rsp_error,
    output logic                        busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    state_t               state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [CTX_W-1:0]     ctx_q;
    logic [IDW-1:0]       id_q;
    logic [IDW-1:0]       rr_ptr_q;
    logic [IDW-1:0]       rr_ptr_d;
    logic [TW-1:0]        timer_q;
    logic                 ev_q;
    logic                 rsp_vld_q;
    logic [IDW-1:0]       rsp_id_q;
    logic [SCHED_W-1:0]   rsp_sched_q;
    logic                 rsp_err_q;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDW-1:0]       pick_idx;
    logic                 pick_any;
    logic [CTX_W-1:0]     pick_ctx;
    logic [2:0]           pick_cls;

    schedule_request_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    assign pick_ctx = req_context[int'(pick_idx)*CTX_W +: CTX_W];
    assign pick_cls = pick_ctx[CTX_W-1 -: 3];
    // Pointer moves just past the winner so it goes to the back of the queue
    assign rr_ptr_d = (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

    // Transaction sequencer: grant, issue to engine, wait with timeout, respond
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            ctx_q       <= '0;
            id_q        <= '0;
            rr_ptr_q    <= '0;
            timer_q     <= '0;
            ev_q        <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sched_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed by a transition below
            ev_q      <= 1'b0;
            rsp_vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_any) begin
                        grant_q  <= pick_onehot;
                        ctx_q    <= pick_ctx;
                        id_q     <= pick_idx;
                        rr_ptr_q <= rr_ptr_d;
                        if (class_valid(pick_cls)) begin
                            state_q <= S_ISSUE;
                            ev_q    <= 1'b1;
                        end else begin
                            // Unknown class never reaches the engine
                            state_q     <= S_RESP;
                            rsp_vld_q   <= 1'b1;
                            rsp_id_q    <= pick_idx;
                            rsp_sched_q <= '0;
                            rsp_err_q   <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A tx on the last allowed cycle still counts as success
                    if (tx_in) begin
                        state_q     <= S_RESP;
                        rsp_vld_q   <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_sched_q <= schedule_in;
                        rsp_err_q   <= 1'b0;
                    end else if (timer_q == TMAX) begin
                        state_q     <= S_RESP;
                        rsp_vld_q   <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_sched_q <= '0;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_RESP: begin
                    grant_q <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant        = grant_q;
    assign ev_out       = ev_q;
    assign context_out  = ctx_q;
    assign rsp_valid    = rsp_vld_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_schedule = rsp_sched_q;
    assign rsp_error    = rsp_err_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_schedule_request_arbiter.sv
// Self-checking bench for schedule_request_arbiter: engine model, response scoreboard,
// vector table plus directed sequences for latency, timeout and async reset.
// Inputs driven #1 after posedge; outputs sampled #1 after posedge or on negedge.
module tb_schedule_request_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CTX_W   = 32;
    localparam int SCHED_W = 32;
    localparam int TIMEOUT = 8;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [NUM_REQ-1:0]         req = '0;
    logic [NUM_REQ*CTX_W-1:0]   req_context = '0;
    logic [NUM_REQ-1:0]         grant;
    logic                       ev_out;
    logic [CTX_W-1:0]           context_out;
    logic                       tx_in = 1'b0;
    logic [SCHED_W-1:0]         schedule_in = '0;
    logic                       rsp_valid;
    logic [1:0]                 rsp_id;
    logic [SCHED_W-1:0]         rsp_schedule;
    logic                       rsp_error;
    logic                       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]         id;
        logic [SCHED_W-1:0] sched;
        logic               err;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    exp_t drv_e;

    typedef struct {
        logic [3:0]  req;
        logic [2:0]  cls;
        int          delay;
        logic [31:0] sched;
        logic [1:0]  id;
        logic        err;
        int          evs;
    } vec_t;
    vec_t vecs[10];

    int          eng_delay = -1;
    int          eng_cnt   = -1;
    logic [31:0] eng_sched = '0;
    int          ev_cnt    = 0;
    int          ev_before = 0;
    bit          ev_pending = 1'b0;
    bit          early;
    logic [31:0] ctx_exp;

    always #5 clk = ~clk;

    schedule_request_arbiter #(
        .NUM_REQ (NUM_REQ),
        .CTX_W   (CTX_W),
        .SCHED_W (SCHED_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_context  (req_context),
        .grant        (grant),
        .ev_out       (ev_out),
        .context_out  (context_out),
        .tx_in        (tx_in),
        .schedule_in  (schedule_in),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_schedule (rsp_schedule),
        .rsp_error    (rsp_error),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctx(input logic [2:0] cls);
        for (int i = 0; i < NUM_REQ; i++)
            req_context[i*CTX_W +: CTX_W] = {cls, 29'(32'h0155_0000 + 32'(i))};
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [31:0] sched, input logic err);
        drv_e.id    = id;
        drv_e.sched = sched;
        drv_e.err   = err;
        exp_q.push_back(drv_e);
    endtask

    task automatic wait_rsp(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // Engine model: tx_in pulses eng_delay cycles after ev_out; schedule_in is junk otherwise
    always @(negedge clk) begin
        tx_in       = 1'b0;
        schedule_in = 32'hDEAD_BEEF;
        if (ev_out) begin
            eng_cnt = eng_delay;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                tx_in       = 1'b1;
                schedule_in = eng_sched;
            end
        end
    end

    // Monitor: scoreboard pop on each response, grant one-hot, no overlapping engine triggers
    always @(negedge clk) begin
        if (rst) begin
            ev_pending = 1'b0;
        end else begin
            if (busy) check("grant_onehot", 32'($onehot(grant)), 32'd1);
            if (ev_out) begin
                ev_cnt++;
                check("ev_overlap", 32'(ev_pending), 32'd0);
                ev_pending = 1'b1;
            end
            if (rsp_valid) begin
                ev_pending = 1'b0;
                check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                    check("rsp_schedule", rsp_schedule, mon_e.sched);
                    check("rsp_error", 32'(rsp_error), 32'(mon_e.err));
                end
            end
        end
    end

    initial begin
        vecs[0] = '{4'b0001, 3'b001, 2,           32'h00FB_A020, 2'd0, 1'b0, 1};
        vecs[1] = '{4'b0100, 3'b000, -1,          32'h1111_1111, 2'd2, 1'b1, 0};
        vecs[2] = '{4'b0010, 3'b010, -1,          32'h2222_2222, 2'd1, 1'b1, 1};
        vecs[3] = '{4'b1111, 3'b100, 1,           32'hA5A5_0003, 2'd2, 1'b0, 1};
        vecs[4] = '{4'b1111, 3'b001, TIMEOUT,     32'h0000_0008, 2'd3, 1'b0, 1};
        vecs[5] = '{4'b1111, 3'b010, TIMEOUT + 1, 32'hFFFF_FFFF, 2'd0, 1'b1, 1};
        vecs[6] = '{4'b1001, 3'b111, -1,          32'h3333_3333, 2'd3, 1'b1, 0};
        vecs[7] = '{4'b0110, 3'b011, -1,          32'h4444_4444, 2'd1, 1'b1, 0};
        vecs[8] = '{4'b0011, 3'b100, 3,           32'h1357_9BDF, 2'd0, 1'b0, 1};
        vecs[9] = '{4'b1000, 3'b010, 5,           32'h8000_0001, 2'd3, 1'b0, 1};

        // Reset state
        set_ctx(3'b001);
        tick();
        check("rst_busy_held", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ev_out", 32'(ev_out), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_schedule", rsp_schedule, 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_context_out", context_out, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single request, engine answers 2 cycles after ev: exact cycle timing
        set_ctx(3'b001);
        ctx_exp   = req_context[31:0];
        eng_delay = 2;
        eng_sched = 32'h00FB_A020;
        push_exp(2'd0, 32'h00FB_A020, 1'b0);
        req = 4'b0001;
        tick();
        check("seq1_ev", 32'(ev_out), 32'd1);
        check("seq1_grant", 32'(grant), 32'h1);
        check("seq1_context", context_out, ctx_exp);
        tick();
        check("seq1_ev_one_cycle", 32'(ev_out), 32'd0);
        tick();
        check("seq1_rsp_not_early", 32'(rsp_valid), 32'd0);
        tick();
        check("seq1_rsp_latency", 32'(rsp_valid), 32'd1);
        check("seq1_grant_in_resp", 32'(grant), 32'h1);
        req = '0;
        tick();
        check("seq1_rsp_one_cycle", 32'(rsp_valid), 32'd0);
        check("seq1_busy_drop", 32'(busy), 32'd0);
        check("seq1_grant_clear", 32'(grant), 32'd0);

        // Bad class: response next cycle, engine untouched (rr_ptr is 1, only req[2] set)
        set_ctx(3'b000);
        push_exp(2'd2, 32'd0, 1'b1);
        ev_before = ev_cnt;
        req = 4'b0100;
        tick();
        check("bad_rsp_latency", 32'(rsp_valid), 32'd1);
        check("bad_grant", 32'(grant), 32'h4);
        check("bad_no_ev", 32'(ev_out), 32'd0);
        req = '0;
        tick();
        check("bad_busy_drop", 32'(busy), 32'd0);
        check("bad_ev_count", 32'(ev_cnt - ev_before), 32'd0);

        // Timeout: exactly TIMEOUT WAIT cycles after ev_out, then error response
        set_ctx(3'b010);
        eng_delay = -1;
        push_exp(2'd1, 32'd0, 1'b1);
        req = 4'b0010;
        tick();
        check("to_ev", 32'(ev_out), 32'd1);
        early = 1'b0;
        repeat (TIMEOUT) begin
            tick();
            if (rsp_valid || !busy) early = 1'b1;
        end
        check("to_no_early_rsp", 32'(early), 32'd0);
        tick();
        check("to_rsp", 32'(rsp_valid), 32'd1);
        req = '0;
        tick();
        check("to_busy_drop", 32'(busy), 32'd0);

        // Async reset mid-WAIT aborts silently; afterwards only req[3] is set
        set_ctx(3'b001);
        eng_delay = -1;
        req = 4'b0100;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ev", 32'(ev_out), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        req       = 4'b1000;
        eng_delay = 1;
        eng_sched = 32'h1234_5678;
        push_exp(2'd3, 32'h1234_5678, 1'b0);
        repeat (2) @(posedge clk);
        #4 rst = 1'b0;
        tick();
        check("arst_rr_restart", 32'(grant), 32'h8);
        wait_rsp("arst_rsp_seen");
        req = '0;
        tick();

        // req[0] drops during WAIT: still answered; req[1] is granted next
        set_ctx(3'b001);
        eng_delay = 4;
        eng_sched = 32'hCAFE_0001;
        push_exp(2'd0, 32'hCAFE_0001, 1'b0);
        req = 4'b0011;
        repeat (2) tick();
        req = 4'b0010;
        push_exp(2'd1, 32'hCAFE_0001, 1'b0);
        wait_rsp("drop_rsp_seen");
        repeat (2) tick();
        check("drop_next_grant", 32'(grant), 32'h2);
        wait_rsp("drop_next_rsp_seen");
        req = '0;
        tick();

        // Fresh reset so the vector table starts from rr_ptr = 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        for (int v = 0; v < 10; v++) begin
            set_ctx(vecs[v].cls);
            eng_delay = vecs[v].delay;
            eng_sched = vecs[v].sched;
            push_exp(vecs[v].id, vecs[v].err ? 32'd0 : vecs[v].sched, vecs[v].err);
            ev_before = ev_cnt;
            req = vecs[v].req;
            wait_rsp("vec_rsp_seen");
            req = '0;
            tick();
            check("vec_ev_count", 32'(ev_cnt - ev_before), 32'(vecs[v].evs));
        end

        // All four held with valid classes: grants rotate 0,1,2,3,0
        set_ctx(3'b001);
        req_context[2*CTX_W + 29 +: 3] = 3'b010;
        req_context[3*CTX_W + 29 +: 3] = 3'b100;
        eng_delay = 1;
        eng_sched = 32'h0F0F_0F0F;
        push_exp(2'd0, 32'h0F0F_0F0F, 1'b0);
        push_exp(2'd1, 32'h0F0F_0F0F, 1'b0);
        push_exp(2'd2, 32'h0F0F_0F0F, 1'b0);
        push_exp(2'd3, 32'h0F0F_0F0F, 1'b0);
        push_exp(2'd0, 32'h0F0F_0F0F, 1'b0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_rsp("rr_rsp_seen");
        req = '0;
        repeat (2) tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
